spi_ram_slave_burst: RTL
========================

// Module: spi_ram_slave_burst
// PURPOSE
//  Parametrised SPI slave with on-chip RAM: successor to the fixed 8-bit SPI wrapper.
//  Adds configurable address/data widths and auto-incrementing write/read pointers
//  (burst access), plus optional per-frame parity. Sits at chip I/O as a host-visible register/memory port.
// PARAMETERS
//  ADDR_W     8           RAM address width; depth = 2**ADDR_W
//  DATA_W     8           RAM word width
//  PAY_W      max(ADDR_W,DATA_W)  frame payload width (localparam, derived)
// PORTS
//  clk         in   1       system clock; SS_n/MOSI sampled on rising edge
//  rst_n       in   1       asynchronous active-low reset
//  SS_n        in   1       slave select, active low; frame boundary
//  MOSI        in   1       serial in, MSB first
//  MISO        out  1       serial out, MSB first
//  busy        out  1       1 while FSM != IDLE
//  parity_err  out  1       sticky parity error flag (0 when SPI_PARITY_EN undefined)
// BEHAVIOUR
//  Reset: state=IDLE, MISO=0, busy=0, parity_err=0, wr_ptr=0, rd_ptr=0, shift regs=0; RAM contents not reset.
//  Frame = 2-bit opcode + PAY_W payload bits, one bit per clk while SS_n=0:
//   00 set wr_ptr=payload[ADDR_W-1:0]; 01 RAM[wr_ptr]=payload[DATA_W-1:0], wr_ptr++;
//   10 set rd_ptr=payload[ADDR_W-1:0]; 11 payload don't-care, readout of RAM[rd_ptr], rd_ptr++.
//  FSM: IDLE -(SS_n=0)-> CHK_CMD; CHK_CMD samples op[1]: 0->WRITE, 1->READ.
//   WRITE/READ shift op[0] then PAY_W payload bits (bit counter 0..PAY_W).
//   After last bit: command executes on next clk (EXEC); op 11 -> READ_OUT, else -> WAIT_SS.
//   READ_OUT: RAM read latency 1 clk (MISO=0), then DATA_W bits driven MSB first, one per clk; then -> WAIT_SS.
//   WAIT_SS: MISO=0; -> IDLE when SS_n=1. Back-to-back frames require SS_n high >=1 clk.
//  Any state: SS_n=1 -> IDLE next clk. Partial frame (before EXEC) discarded, no pointer/RAM change.
//   Abort during READ_OUT: rd_ptr already incremented (increment is at EXEC).
//  Pointers wrap modulo 2**ADDR_W (0xFF+1 -> 0x00 for ADDR_W=8).
//  Payload bits above ADDR_W/DATA_W ignored. Op 11 before any op 10 reads from rd_ptr=0.
//  rst_n low mid-frame: immediate return to reset values; no RAM write occurs that cycle.
// CONFIGURATION
//  SPI_PARITY_EN defined: frame carries one extra even-parity bit after payload (covers
//   opcode+payload). Mismatch -> frame discarded (no RAM/pointer effect, no readout), parity_err=1
//   until reset. Readout bits carry no parity.
//  SPI_PARITY_EN undefined: no parity bit, frame = 2+PAY_W bits, parity_err tied 0.
// STRUCTURE
//  Shared package spi_ram_pkg: opcode constants (OP_WADDR, OP_WDATA, OP_RADDR, OP_RDATA),
//   FSM state encodings (IDLE, CHK_CMD, WRITE, READ, EXEC, READ_OUT, WAIT_SS).
//  One sub-module: spi_ram_mem (single-port synchronous RAM, ADDR_W x DATA_W, 1-clk read latency).
//  Top holds FSM, bit counter, shift-in/shift-out registers, wr_ptr/rd_ptr, parity logic.
// TESTING (ADDR_W=8, DATA_W=8)
//  Reset asserted mid-frame -> MISO=0, busy=0, next frame decodes normally from IDLE.
//  00_0x10, then 01_0xAB, 01_0xCD, 10_0x10, 11_x, 11_x -> reads return 0xAB then 0xCD (burst increment).
//  00_0xFF, 01_0x11, 01_0x22; 10_0x00, 11_x -> 0x22 (wr_ptr wrap to 0x00).
//  01_0x55 frame aborted (SS_n=1) after 5 bits -> RAM/wr_ptr unchanged; subsequent read of old addr returns prior value.
//  11_x then SS_n=1 after 3 readout bits -> next 11_x returns RAM[rd_ptr+1].
//  SPI_PARITY_EN: 01_0xAB with wrong parity -> parity_err=1, RAM unchanged; correct parity -> write lands.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM slave: opcodes and FSM state encodings.
package spi_ram_pkg;

    // Two-bit frame opcodes, sent MSB first at the start of each frame
    localparam logic [1:0] OP_WADDR = 2'b00;
    localparam logic [1:0] OP_WDATA = 2'b01;
    localparam logic [1:0] OP_RADDR = 2'b10;
    localparam logic [1:0] OP_RDATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CHK_CMD  = 3'd1,
        WRITE    = 3'd2,
        READ     = 3'd3,
        EXEC     = 3'd4,
        READ_OUT = 3'd5,
        WAIT_SS  = 3'd6
    } state_t;

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port synchronous RAM, 2**ADDR_W x DATA_W, one-clock read latency.
// Ports:
//   clk    in   clock
//   we     in   write enable (write lands on rising edge)
//   addr   in   shared read/write address
//   wdata  in   write data
//   rdata  out  registered read data (read-before-write), valid the clock after addr
// Contents are not reset.
module spi_ram_mem #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port and registered read share one address
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/spi_ram_slave_burst.sv
// SPI slave with on-chip RAM and auto-incrementing write/read pointers (burst access).
// Frame: 2-bit opcode + PAY_W payload bits (+ even-parity bit when SPI_PARITY_EN
// is defined), MSB first, one bit per clk while SS_n is low. The first clock with
// SS_n low is a select cycle; the opcode MSB is sampled on the following clock.
//   00 wr_ptr = payload      01 RAM[wr_ptr] = payload, wr_ptr++
//   10 rd_ptr = payload      11 read RAM[rd_ptr] out on MISO, rd_ptr++
// Read data appears on MISO starting two clocks after the last frame bit
// (one idle clock for RAM latency), DATA_W bits MSB first.
// Optional feature macro: SPI_PARITY_EN (per-frame even parity, sticky parity_err).
// Ports:
//   clk         in   system clock, SS_n/MOSI sampled on rising edge
//   rst_n       in   asynchronous active-low reset
//   SS_n        in   slave select, active low, frame boundary
//   MOSI        in   serial in, MSB first
//   MISO        out  serial out, MSB first (registered)
//   busy        out  1 while FSM is not IDLE (registered)
//   parity_err  out  sticky parity error (tied 0 without SPI_PARITY_EN)
module spi_ram_slave_burst
    import spi_ram_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic busy,
    output logic parity_err
);

    localparam int unsigned PAY_W    = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
`ifdef SPI_PARITY_EN
    localparam int unsigned PAR_W    = 1;
`else
    localparam int unsigned PAR_W    = 0;
`endif
    localparam int unsigned FRAME_W  = 2 + PAY_W + PAR_W;
    localparam int unsigned LAST_BIT = PAY_W + PAR_W;
    localparam int unsigned CNT_MAX  = (LAST_BIT > DATA_W) ? LAST_BIT : DATA_W;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [FRAME_W-1:0]  shift_in;
    logic [DATA_W-1:0]   shift_out;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;

    logic [1:0]          op_c;
    logic [PAY_W-1:0]    payload_c;
    logic                frame_ok_c;
    logic                mem_we_c;
    logic [ADDR_W-1:0]   mem_addr_c;
    logic [DATA_W-1:0]   mem_rdata;

    // Frame field decode from the completed shift-in register
    assign op_c      = shift_in[FRAME_W-1 -: 2];
    assign payload_c = shift_in[PAR_W +: PAY_W];
`ifdef SPI_PARITY_EN
    assign frame_ok_c = ~(^shift_in);
`else
    assign frame_ok_c = 1'b1;
`endif

    // A frame counts only if SS_n is still low during EXEC, matching the FSM's SS_n priority
    assign mem_we_c   = (state == EXEC) && !SS_n && frame_ok_c && (op_c == OP_WDATA);
    assign mem_addr_c = (op_c == OP_RDATA) ? rd_ptr : wr_ptr;

    spi_ram_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_c),
        .addr  (mem_addr_c),
        .wdata (payload_c[DATA_W-1:0]),
        .rdata (mem_rdata)
    );

    // Frame FSM, counters, pointers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            shift_in  <= '0;
            shift_out <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            MISO      <= 1'b0;
            busy      <= 1'b0;
`ifdef SPI_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else if (SS_n) begin
            state <= IDLE;
            cnt   <= '0;
            MISO  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            busy <= 1'b1;
            case (state)
                IDLE: begin
                    state    <= CHK_CMD;
                    cnt      <= '0;
                    shift_in <= '0;
                    MISO     <= 1'b0;
                end
                CHK_CMD: begin
                    shift_in <= {shift_in[FRAME_W-2:0], MOSI};
                    state    <= MOSI ? READ : WRITE;
                end
                WRITE, READ: begin
                    shift_in <= {shift_in[FRAME_W-2:0], MOSI};
                    cnt      <= cnt + 1'b1;
                    if (cnt == CNT_W'(LAST_BIT)) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    cnt   <= '0;
                    state <= WAIT_SS;
                    if (frame_ok_c) begin
                        case (op_c)
                            OP_WADDR: wr_ptr <= payload_c[ADDR_W-1:0];
                            OP_WDATA: wr_ptr <= wr_ptr + 1'b1;
                            OP_RADDR: rd_ptr <= payload_c[ADDR_W-1:0];
                            OP_RDATA: begin
                                rd_ptr <= rd_ptr + 1'b1;
                                state  <= READ_OUT;
                            end
                        endcase
                    end else begin
`ifdef SPI_PARITY_EN
                        parity_err <= 1'b1;
`endif
                    end
                end
                READ_OUT: begin
                    // cnt 0 waits out RAM latency and loads the word; 1..DATA_W shift it out
                    cnt <= cnt + 1'b1;
                    if (cnt == '0) begin
                        MISO      <= mem_rdata[DATA_W-1];
                        shift_out <= {mem_rdata[DATA_W-2:0], 1'b0};
                    end else if (cnt == CNT_W'(DATA_W)) begin
                        MISO  <= 1'b0;
                        state <= WAIT_SS;
                    end else begin
                        MISO      <= shift_out[DATA_W-1];
                        shift_out <= {shift_out[DATA_W-2:0], 1'b0};
                    end
                end
                WAIT_SS: begin
                    MISO <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef SPI_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule
